// File: rtl/com_identify.sv
// com_identify: hunts sync-framed commands in the selected comm RX FIFO, checks the checksum,
// then forwards the payload to the CPU A/B UART TX FIFOs or issues a forced CPU switch.
module com_identify #(
   parameter int         CNT_W    = 5,
   parameter int         MAX_LEN  = 16,
   parameter logic [7:0] HDR0     = 8'hEB,
   parameter logic [7:0] HDR1     = 8'h90,
   parameter logic [7:0] TYPE_FWD = 8'h01,
   parameter logic [7:0] TYPE_SWI = 8'h5A
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [7:0]       rec_command,
   input  logic [CNT_W-1:0] com_count,
   input  logic             command_time_out_d,
   output logic             com_pop,
   output logic [7:0]       tdr_cpuAB,
   output logic             tf_push_cpuAB,
   output logic             force_swi,
   output logic             com_swi,
   output logic             error
);
   localparam int IW = $clog2(MAX_LEN);
   typedef enum logic [2:0] {HUNT0, HUNT1, TYPE, LEN, PAYLOAD, CSUM, FWD, SWI} state_t;
   state_t     state;
   logic       gap, ph, rx, in_frame;
   logic [7:0] typ, len, idx, csum;
   logic [7:0] pay [MAX_LEN];
   assign rx       = state inside {HUNT0, HUNT1, TYPE, LEN, PAYLOAD, CSUM};
   assign in_frame = state inside {TYPE, LEN, PAYLOAD, CSUM};
   // the cycle after a pop is skipped so the FIFO head and count can settle
   assign com_pop  = rst_n && rx && !gap && !command_time_out_d && (com_count != '0);
   always_ff @(posedge clk)
      if (com_pop && state == PAYLOAD) pay[idx[IW-1:0]] <= rec_command;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state         <= HUNT0;
         gap           <= 1'b0;
         ph            <= 1'b0;
         typ           <= '0;
         len           <= '0;
         idx           <= '0;
         csum          <= '0;
         tdr_cpuAB     <= '0;
         tf_push_cpuAB <= 1'b0;
         force_swi     <= 1'b0;
         com_swi       <= 1'b0;
         error         <= 1'b0;
      end else begin
         gap           <= com_pop;
         tf_push_cpuAB <= 1'b0;
         force_swi     <= 1'b0;
         if (rx && command_time_out_d) begin
            error <= error | in_frame;
            state <= HUNT0;
         end else if (com_pop) begin
            case (state)
               HUNT0: if (rec_command == HDR0) state <= HUNT1;
               HUNT1: state <= rec_command == HDR1 ? TYPE : rec_command == HDR0 ? HUNT1 : HUNT0;
               TYPE: begin
                  typ   <= rec_command;
                  csum  <= rec_command;
                  state <= (rec_command == TYPE_FWD || rec_command == TYPE_SWI) ? LEN : HUNT0;
                  if (rec_command != TYPE_FWD && rec_command != TYPE_SWI) error <= 1'b1;
               end
               LEN: begin
                  len  <= rec_command;
                  csum <= csum + rec_command;
                  idx  <= '0;
                  if (rec_command == '0 || rec_command > 8'(MAX_LEN) ||
                      (typ == TYPE_SWI && rec_command != 8'd1)) begin
                     error <= 1'b1;
                     state <= HUNT0;
                  end else state <= PAYLOAD;
               end
               PAYLOAD: begin
                  csum <= csum + rec_command;
                  idx  <= idx + 8'd1;
                  if (idx == len - 8'd1) state <= CSUM;
               end
               CSUM: begin
                  idx <= '0;
                  ph  <= 1'b0;
                  if (rec_command != csum) begin
                     error <= 1'b1;
                     state <= HUNT0;
                  end else if (typ == TYPE_FWD) state <= FWD;
                  else if (pay[0][7:1] == 7'd0) state <= SWI;
                  else begin
                     error <= 1'b1;
                     state <= HUNT0;
                  end
               end
               default: ;
            endcase
         end else if (state == FWD) begin
            ph <= !ph;
            if (!ph) begin
               tdr_cpuAB     <= pay[idx[IW-1:0]];
               tf_push_cpuAB <= 1'b1;
               idx           <= idx + 8'd1;
               if (idx == len - 8'd1) begin
                  error <= 1'b0;
                  state <= HUNT0;
               end
            end
         end else if (state == SWI) begin
            com_swi   <= pay[0][0];
            force_swi <= 1'b1;
            error     <= 1'b0;
            state     <= HUNT0;
         end
      end
endmodule

// File: tb/tb_com_identify.sv
// tb_com_identify: random and directed frames checked every cycle against a byte-stream frame model.
module tb_com_identify;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] rec_command = 8'h00;
   logic [4:0] com_count = 5'd0;
   logic       command_time_out_d = 1'b0;
   logic       com_pop, tf_push_cpuAB, force_swi, com_swi, error;
   logic [7:0] tdr_cpuAB;
   always #5 clk = ~clk;
   com_identify dut (
      .clk(clk), .rst_n(rst_n), .rec_command(rec_command), .com_count(com_count),
      .command_time_out_d(command_time_out_d), .com_pop(com_pop), .tdr_cpuAB(tdr_cpuAB),
      .tf_push_cpuAB(tf_push_cpuAB), .force_swi(force_swi), .com_swi(com_swi), .error(error)
   );
   int checks = 0, passed = 0, cyc = 0, nforce = 0, dpops = 0;
   logic rst_v = 1'b0, to_v = 1'b0;
   logic [7:0] fq[$], sq[$], frm[$], fwdq[$], dlog[$], mlog[$];
   int dcyc[$];
   logic swi_pend = 0, m_arg = 0, fwd_ph = 0, m_gap = 0, m_pop = 0, swi_at_force = 0;
   logic e_push = 0, e_force = 0, e_swi = 0, e_err = 0, n_push, n_force, n_swi, n_err;
   logic [7:0] e_tdr = 0, n_tdr;
   function automatic void chk(string nm, int act, int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
   endfunction
   task automatic reject();
      n_err = 1'b1;
      frm.delete();
   endtask
   // frame model: frm holds the bytes of the frame being assembled since its sync byte
   task automatic parse(input logic [7:0] b);
      int n;
      logic [7:0] s;
      case (frm.size())
         0: if (b == 8'hEB) frm.push_back(b);
         1: if (b == 8'h90) frm.push_back(b); else if (b != 8'hEB) frm.delete();
         2: if (b == 8'h01 || b == 8'h5A) frm.push_back(b); else reject();
         3: if (b == 0 || b > 16 || (frm[2] == 8'h5A && b != 1)) reject(); else frm.push_back(b);
         default: begin
            n = int'(frm[3]);
            if (frm.size() < 4 + n) frm.push_back(b);
            else begin
               s = 0;
               for (int i = 2; i < frm.size(); i++) s += frm[i];
               if (b != s) reject();
               else if (frm[2] == 8'h01) begin
                  for (int i = 4; i < 4 + n; i++) fwdq.push_back(frm[i]);
                  fwd_ph = 0;
                  frm.delete();
               end else if (frm[4] <= 8'd1) begin
                  swi_pend = 1;
                  m_arg = frm[4][0];
                  frm.delete();
               end else reject();
            end
         end
      endcase
   endtask
   task automatic cycle();
      @(negedge clk);
      rst_n = rst_v;
      command_time_out_d = to_v;
      com_count = 5'(fq.size());
      rec_command = fq.size() != 0 ? fq[0] : 8'h00;
      if (!rst_n) begin
         frm.delete(); fwdq.delete();
         swi_pend = 0; m_gap = 0; e_push = 0; e_tdr = 0; e_force = 0; e_swi = 0; e_err = 0;
      end
      n_push = 0; n_force = 0; n_tdr = e_tdr; n_swi = e_swi; n_err = e_err; m_pop = 0;
      if (!rst_n) ;
      else if (fwdq.size() != 0) begin
         if (!fwd_ph) begin
            n_push = 1;
            n_tdr = fwdq.pop_front();
            if (fwdq.size() == 0) n_err = 0;
         end
         fwd_ph = !fwd_ph;
      end else if (swi_pend) begin
         n_force = 1; n_swi = m_arg; n_err = 0; swi_pend = 0;
      end else if (command_time_out_d) begin
         if (frm.size() >= 2) n_err = 1;
         frm.delete();
      end else if (!m_gap && fq.size() != 0) begin
         m_pop = 1;
         parse(fq[0]);
      end
      m_gap = m_pop;
      #1;
      chk("com_pop", int'(com_pop), int'(m_pop));
      chk("tf_push", int'(tf_push_cpuAB), int'(e_push));
      if (e_push) chk("tdr", int'(tdr_cpuAB), int'(e_tdr));
      chk("force_swi", int'(force_swi), int'(e_force));
      chk("com_swi", int'(com_swi), int'(e_swi));
      chk("error", int'(error), int'(e_err));
      if (tf_push_cpuAB) begin dlog.push_back(tdr_cpuAB); dcyc.push_back(cyc); end
      if (e_push) mlog.push_back(e_tdr);
      if (force_swi) begin nforce++; swi_at_force = com_swi; end
      if (com_pop) dpops++;
      if (m_pop) void'(fq.pop_front());
      e_push = n_push; e_tdr = n_tdr; e_force = n_force; e_swi = n_swi; e_err = n_err;
      cyc++;
   endtask
   task automatic run(int n);
      repeat (n) cycle();
   endtask
   task automatic clr_logs();
      dlog.delete(); dcyc.delete(); mlog.delete(); nforce = 0;
   endtask
   task automatic gen();
      int k, n;
      logic [7:0] ty, s, b;
      repeat ($urandom_range(2)) sq.push_back(8'($urandom));
      k = $urandom_range(9);
      ty = k < 6 ? 8'h01 : k < 9 ? 8'h5A : 8'($urandom);
      if (ty == 8'h5A) n = $urandom_range(5) == 0 ? $urandom_range(3) : 1;
      else n = $urandom_range(9) == 0 ? $urandom_range(1) * 17 : $urandom_range(16, 1);
      if ($urandom_range(4) == 0) sq.push_back(8'hEB);
      sq.push_back(8'hEB); sq.push_back(8'h90); sq.push_back(ty); sq.push_back(8'(n));
      s = ty + 8'(n);
      for (int i = 0; i < n; i++) begin
         b = ty == 8'h5A ? 8'($urandom_range(2)) : 8'($urandom);
         sq.push_back(b);
         s += b;
      end
      sq.push_back($urandom_range(5) == 0 ? s ^ 8'h01 : s);
   endtask
   initial begin
      logic [7:0] s;
      int n, bound;
      #1 rst_n = 1'b0;
      rst_v = 1'b0;
      run(3);
      rst_v = 1'b1;
      run(2);
      // forward frame: 01+03+11+22+33 = 6A
      clr_logs();
      fq = {fq, 8'hEB, 8'h90, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
      run(40);
      chk("fwd_count", dlog.size(), 3);
      if (dlog.size() == 3) begin
         chk("fwd_b0", int'(dlog[0]), 'h11);
         chk("fwd_b1", int'(dlog[1]), 'h22);
         chk("fwd_b2", int'(dlog[2]), 'h33);
         chk("fwd_gap", dcyc[1] - dcyc[0], 2);
      end
      chk("model_fwd_count", mlog.size(), 3);
      chk("fwd_err", int'(error), 0);
      chk("fwd_noforce", nforce, 0);
      // forced switch to B then back to A
      clr_logs();
      fq = {fq, 8'hEB, 8'h90, 8'h5A, 8'h01, 8'h01, 8'h5C};
      run(30);
      chk("swi_b_pulses", nforce, 1);
      chk("swi_b_at_force", int'(swi_at_force), 1);
      chk("swi_b_level", int'(com_swi), 1);
      fq = {fq, 8'hEB, 8'h90, 8'h5A, 8'h01, 8'h00, 8'h5B};
      run(30);
      chk("swi_a_pulses", nforce, 2);
      chk("swi_a_level", int'(com_swi), 0);
      // bad checksum, then a good frame clears the error
      clr_logs();
      fq = {fq, 8'hEB, 8'h90, 8'h01, 8'h02, 8'hAA, 8'hBB, 8'h00};
      run(30);
      chk("badcs_err", int'(error), 1);
      chk("badcs_pushes", dlog.size(), 0);
      fq = {fq, 8'hEB, 8'h90, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
      run(40);
      chk("good_clears_err", int'(error), 0);
      // timeout mid-frame with a byte waiting
      fq = {fq, 8'hEB, 8'h90, 8'h01};
      run(12);
      fq.push_back(8'h03);
      to_v = 1'b1;
      cycle();
      chk("to_nopop", int'(com_pop), 0);
      chk("to_fifo_kept", fq.size(), 1);
      to_v = 1'b0;
      cycle();
      chk("to_err", int'(error), 1);
      run(10);
      // overlapping sync, then length 0 and length 17
      clr_logs();
      fq = {fq, 8'hEB, 8'hEB, 8'h90, 8'h01, 8'h01, 8'h11, 8'h13};
      run(30);
      chk("overlap_pushes", dlog.size(), 1);
      chk("overlap_err", int'(error), 0);
      fq = {fq, 8'hEB, 8'h90, 8'h01, 8'h00};
      run(20);
      chk("len0_err", int'(error), 1);
      fq = {fq, 8'hEB, 8'h90, 8'h01, 8'h01, 8'h11, 8'h13};
      run(30);
      chk("len_ok_clears", int'(error), 0);
      fq = {fq, 8'hEB, 8'h90, 8'h01, 8'h11};
      run(20);
      chk("len17_err", int'(error), 1);
      // empty FIFO never popped
      n = dpops;
      run(20);
      chk("no_pop_empty", dpops - n, 0);
      // reset during forwarding
      clr_logs();
      fq = {fq, 8'hEB, 8'h90, 8'h01, 8'h10};
      s = 8'h11;
      for (int i = 0; i < 16; i++) begin fq.push_back(8'(i * 3 + 1)); s += 8'(i * 3 + 1); end
      fq.push_back(s);
      bound = 0;
      while (!tf_push_cpuAB && bound < 100) begin cycle(); bound++; end
      chk("fwd_started", int'(tf_push_cpuAB), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_push_now", int'(tf_push_cpuAB), 0);
      rst_v = 1'b0;
      run(2);
      rst_v = 1'b1;
      n = dlog.size();
      run(60);
      chk("rst_no_more_push", dlog.size() - n, 0);
      chk("rst_err", int'(error), 0);
      // randomized traffic
      for (int i = 0; i < 5000; i++) begin
         if (sq.size() == 0) gen();
         if (fq.size() < 31 && $urandom_range(3) != 0) fq.push_back(sq.pop_front());
         to_v = $urandom_range(120) == 0;
         rst_v = !(i >= 2500 && i < 2502);
         cycle();
      end
      to_v = 1'b0;
      rst_v = 1'b1;
      run(80);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
